fetch_queue: RTL

- Consumer end of the IFU fetch interface: buffers fetch bundles (FETCH_WIDTH instruction words plus pc and pc+4) from the registered IFU output stage and hands them to decode with a valid/ready handshake.
- Drives the `stall` that freezes the IFU and its output flops.
- Sits between the IFU output flops and the decode/rename front end.
- Discards wrong-path bundles on a branch/jump redirect.

---
 rtl/fetch_queue_if.sv | 51 +++++
 rtl/fetch_queue.sv | 90 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch bundle channel between the IFU output flops, the fetch queue and decode.
// The slave modport is the queue's view; the master modport is the IFU/decode side.
interface fetch_queue_if #(
    parameter int FETCH_WIDTH     = 2,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int DEPTH           = 4,
    parameter int CNT_W           = $clog2(DEPTH + 1)
);
    logic                             in_valid;
    logic [FETCH_WIDTH-1:0][31:0]     in_inst;
    logic [INST_ADDR_WIDTH-1:0]       in_pc;
    logic [INST_ADDR_WIDTH-1:0]       in_pc_plus_4;
    logic                             flush;
    logic                             stall;
    logic                             out_valid;
    logic                             out_ready;
    logic [FETCH_WIDTH-1:0][31:0]     out_inst;
    logic [INST_ADDR_WIDTH-1:0]       out_pc;
    logic [INST_ADDR_WIDTH-1:0]       out_pc_plus_4;
    logic [CNT_W-1:0]                 occupancy;

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        input  in_pc_plus_4,
        input  flush,
        input  out_ready,
        output stall,
        output out_valid,
        output out_inst,
        output out_pc,
        output out_pc_plus_4,
        output occupancy
    );

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        output in_pc_plus_4,
        output flush,
        output out_ready,
        input  stall,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  out_pc_plus_4,
        input  occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch bundle queue between the IFU output flops and decode.
// Back-pressures the IFU with a registered stall and discards wrong-path bundles on redirect.
module fetch_queue #(
    parameter int FETCH_WIDTH     = 2,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int DEPTH           = 4,
    parameter int CNT_W           = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][31:0]  inst;
        logic [INST_ADDR_WIDTH-1:0]    pc;
        logic [INST_ADDR_WIDTH-1:0]    pc_plus_4;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           rd_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             drop_next;
    logic             full;
    logic             not_empty;
    logic             enq;
    logic             deq;

    // stall depends only on count so the IFU never sees a path from decode or redirect
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        not_empty = (count != '0);
        enq       = bus.in_valid && !full && !bus.flush && !drop_next;
        deq       = not_empty && bus.out_ready && !bus.flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_next <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_next <= 1'b1;
        end else begin
            drop_next <= 1'b0;
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: nothing is visible until count marks it valid
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{inst:      bus.in_inst,
                             pc:        bus.in_pc,
                             pc_plus_4: bus.in_pc_plus_4};
        end
    end

    always_comb begin
        rd_entry          = mem[rd_ptr];
        bus.stall         = full;
        bus.out_valid     = not_empty;
        bus.occupancy     = count;
        bus.out_inst      = '0;
        bus.out_pc        = '0;
        bus.out_pc_plus_4 = '0;
        if (not_empty) begin
            bus.out_inst      = rd_entry.inst;
            bus.out_pc        = rd_entry.pc;
            bus.out_pc_plus_4 = rd_entry.pc_plus_4;
        end
    end
endmodule
